// File: rtl/multicycle_maindec.sv
// Multicycle MIPS main control FSM.
// Sequences each instruction through fetch / decode / execute / memory /
// writeback, stalls on a memory-ready handshake, flags illegal opcodes and
// counts retired instructions.
module multicycle_maindec #(
  parameter int unsigned CNT_W         = 32,
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter bit          ILLEGAL_HALT  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             memready,
  output logic             pcwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             memwrite,
  output logic             memread,
  output logic             iord,
  output logic             regdst,
  output logic             memtoreg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [1:0]       aluop,
  output logic             branch,
  output logic             bne,
  output logic             signorzero,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e           state_q, state_d;
  logic [5:0]       opq_q, opq_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  // Memory completion as seen by the FSM; without the handshake every access
  // completes in one cycle.
  logic rdy;
  assign rdy = MEM_HANDSHAKE ? memready : 1'b1;

  // Ungated enables; the write/read strobes are masked by reset below.
  logic pcwrite_c, irwrite_c, regwrite_c, memwrite_c, memread_c;
  logic retire;

  // State, latched opcode and retire counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      opq_q     <= 6'd0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      opq_q     <= opq_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and per-state control outputs.
  always_comb begin
    state_d    = state_q;
    opq_d      = opq_q;
    pcwrite_c  = 1'b0;
    irwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    memwrite_c = 1'b0;
    memread_c  = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    branch     = 1'b0;
    bne        = 1'b0;
    signorzero = 1'b0;
    illegal    = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread_c = 1'b1;
        alusrcb   = 2'b01;
        // IR load and PC+4 happen only on the cycle the read completes.
        irwrite_c = rdy;
        pcwrite_c = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;   // branch target precompute
        opq_d   = op;
        case (op)
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_RTYPE:        state_d = S_EXECUTE;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_ADDI, OP_ORI: state_d = S_IMMEX;
          OP_J:            state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (opq_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord      = 1'b1;
        memread_c = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_c = 1'b1;
        // A store retires on the cycle memory accepts it.
        if (rdy) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = (opq_q == OP_BEQ);
        bne     = (opq_q == OP_BNE);
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_IMMEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        aluop      = (opq_q == OP_ORI) ? 2'b11 : 2'b00;
        signorzero = (opq_q == OP_ORI);
        state_d    = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite_c = 1'b1;
        // Keep the extension mode stable through writeback.
        signorzero = (opq_q == OP_ORI);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pcsrc     = 2'b10;
        pcwrite_c = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        // Only reset leaves HALT.
        illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Retired-instruction count wraps naturally at 2^CNT_W.
  always_comb begin
    instret_d = instret_q;
    if (retire) instret_d = instret_q + CNT_W'(1);
  end

  // Strobes must stay quiet while reset is held, even though the state
  // register already shows FETCH.
  assign pcwrite  = pcwrite_c  & ~reset;
  assign irwrite  = irwrite_c  & ~reset;
  assign regwrite = regwrite_c & ~reset;
  assign memwrite = memwrite_c & ~reset;
  assign memread  = memread_c  & ~reset;

  assign state   = state_q;
  assign instret = instret_q;

endmodule
